// File: rtl/gs_pkg.sv
// Shared types and constants for the GoldenSnitch load/store unit.
package gs_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // addr keeps only the byte offset; the word address lives in the dmem_addr register.
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_op_t;

endpackage

// File: rtl/gs_lsu_align.sv
// Combinational lane logic: store byte enables/replication/fault check, load extract/extend.
module gs_lsu_align
  import gs_pkg::*;
(
  input  logic        st_is_store_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        st_err_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic        misaligned;
  logic        illegal;
  logic [31:0] lane;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    misaligned = 1'b0;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_addr_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = 4'b0011 << st_addr_i;
        st_wdata_o = {2{st_wdata_i[15:0]}};
        misaligned = st_addr_i[0];
      end
      default: begin
        misaligned = |st_addr_i;
      end
    endcase
    if (st_is_store_i) begin
      illegal = st_funct3_i[2];
    end else begin
      illegal = (st_funct3_i == 3'b011) || (st_funct3_i[2:1] == 2'b11);
    end
    st_err_o = misaligned | illegal;
  end

  assign lane = ld_rdata_i >> {ld_addr_i, 3'b000};

  always_comb begin
    ld_data_o = lane;
    case (ld_funct3_i)
      LSU_B:   ld_data_o = {{24{lane[7]}}, lane[7:0]};
      LSU_BU:  ld_data_o = {24'h0, lane[7:0]};
      LSU_H:   ld_data_o = {{16{lane[15]}}, lane[15:0]};
      LSU_HU:  ld_data_o = {16'h0, lane[15:0]};
      default: ld_data_o = lane;
    endcase
  end

endmodule

// File: rtl/gs_lsu.sv
// Load/store unit: single-outstanding req/gnt/rvalid data bus with registered writeback.
module gs_lsu
  import gs_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd_addr,
  output logic              dmem_req,
  input  logic              dmem_gnt,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              lsu_rd_wen,
  output logic [4:0]        lsu_rd_addr,
  output logic [31:0]       lsu_rd_data,
  output logic              lsu_err
);

  lsu_state_e        state_q, state_d;
  lsu_op_t           op_q, op_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic              rd_wen_q, rd_wen_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              err_q, err_d;

  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              st_err;
  logic [31:0]       ld_data;

  gs_lsu_align u_align (
    .st_is_store_i (ex_is_store),
    .st_funct3_i   (ex_funct3),
    .st_addr_i     (ex_addr[1:0]),
    .st_wdata_i    (ex_wdata),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .st_err_o      (st_err),
    .ld_funct3_i   (op_q.funct3),
    .ld_addr_i     (op_q.addr),
    .ld_rdata_i    (dmem_rdata),
    .ld_data_o     (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    req_d     = req_q;
    addr_d    = addr_q;
    be_d      = be_q;
    rd_wen_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (st_err) begin
            err_d = 1'b1;
          end else begin
            op_d.is_store = ex_is_store;
            op_d.funct3   = ex_funct3;
            op_d.addr     = ex_addr[1:0];
            op_d.wdata    = st_wdata;
            op_d.rd       = ex_rd_addr;
            req_d         = 1'b1;
            addr_d        = {ex_addr[ADDR_W-1:2], 2'b00};
            be_d          = st_be;
            state_d       = StReq;
          end
        end
      end
      StReq: begin
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (dmem_rvalid) begin
          state_d = StIdle;
          if (!op_q.is_store) begin
            rd_wen_d  = |op_q.rd;
            rd_addr_d = op_q.rd;
            rd_data_d = ld_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      rd_wen_q  <= rd_wen_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  assign ex_ready    = (state_q == StIdle);
  assign dmem_req    = req_q;
  assign dmem_addr   = addr_q;
  assign dmem_we     = op_q.is_store;
  assign dmem_be     = be_q;
  assign dmem_wdata  = op_q.wdata;
  assign lsu_rd_wen  = rd_wen_q;
  assign lsu_rd_addr = rd_addr_q;
  assign lsu_rd_data = rd_data_q;
  assign lsu_err     = err_q;

endmodule

// File: tb/tb_gs_lsu.sv
// Scoreboard bench for gs_lsu: driver pushes model expectations, a negedge monitor pops them.
module tb_gs_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b0;
  logic [31:0] ex_addr = 32'h0;
  logic [31:0] ex_wdata = 32'h0;
  logic [4:0]  ex_rd_addr = 5'h0;
  logic        dmem_req;
  logic        dmem_gnt = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        lsu_rd_wen;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_rd_data;
  logic        lsu_err;

  always #5 clk = ~clk;

  gs_lsu #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_is_store (ex_is_store),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_rd_addr  (ex_rd_addr),
    .dmem_req    (dmem_req),
    .dmem_gnt    (dmem_gnt),
    .dmem_addr   (dmem_addr),
    .dmem_we     (dmem_we),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .lsu_rd_wen  (lsu_rd_wen),
    .lsu_rd_addr (lsu_rd_addr),
    .lsu_rd_data (lsu_rd_data),
    .lsu_err     (lsu_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  int   err_pend = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, fault rule, lane placement and extension.
  function automatic int op_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit op_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int  n   = op_bytes(f3);
    bit  ill = st ? f3[2] : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    return ill || ((a % n) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int         n = op_bytes(f3);
    logic [7:0] m;
    m = 8'(((1 << n) - 1) << (a % 4));
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    int n = op_bytes(f3);
    if (n == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] r);
    int          n = op_bytes(f3);
    logic [31:0] lane;
    logic [31:0] mask;
    logic [31:0] v;
    lane = r >> (8 * (a % 4));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 1);
    v    = lane & mask;
    if (!f3[2] && n < 4 && lane[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Monitor: compares requests at grant, writebacks and error pulses against the queues.
  initial begin
    bit   prev_hold = 1'b0;
    req_t prev;
    req_t e;
    wb_t  w;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (dmem_req) begin
          check("ready_low_during_req", ex_ready, 0);
          if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: dmem_req=1 addr %h with no pending op", dmem_addr);
          end
          if (prev_hold) begin
            check("req_stable_addr", dmem_addr, prev.addr);
            check("req_stable_be", dmem_be, prev.be);
            check("req_stable_we", dmem_we, prev.we);
          end
          if (dmem_gnt && exp_req.size() != 0) begin
            e = exp_req.pop_front();
            check("req_addr", dmem_addr, e.addr);
            check("req_we", dmem_we, e.we);
            check("req_be", dmem_be, e.be);
            if (e.we) check("req_wdata", dmem_wdata, e.wdata);
          end
        end
        if (lsu_rd_wen) begin
          if (exp_wb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wb: rd %0d data %h with none expected", lsu_rd_addr,
                     lsu_rd_data);
          end else begin
            w = exp_wb.pop_front();
            check("wb_rd", lsu_rd_addr, w.rd);
            check("wb_data", lsu_rd_data, w.data);
          end
        end
        if (lsu_err) begin
          if (err_pend == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_err: lsu_err=1 got 1 expected 0");
          end else begin
            err_pend--;
          end
        end
        prev_hold  = dmem_req && !dmem_gnt;
        prev.addr  = dmem_addr;
        prev.be    = dmem_be;
        prev.we    = dmem_we;
        prev.wdata = dmem_wdata;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_ex_ready", ex_ready, 1);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_be", dmem_be, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wen", lsu_rd_wen, 0);
    check("rst_rd_addr", lsu_rd_addr, 0);
    check("rst_rd_data", lsu_rd_data, 0);
    check("rst_err", lsu_err, 0);
  endtask

  // Driver: called positioned #1 after a rising edge; returns in the same position.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int gd, input int rvd, input bit abort);
    bit   err = op_err(st, f3, a);
    req_t r;
    wb_t  w;
    int   n = 0;
    while (!ex_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_accept", ex_ready, 1);
    ex_valid    = 1'b1;
    ex_is_store = st;
    ex_funct3   = f3;
    ex_addr     = a;
    ex_wdata    = wd;
    ex_rd_addr  = rd;
    if (err) begin
      err_pend++;
    end else begin
      r.addr  = {a[31:2], 2'b00};
      r.we    = st;
      r.be    = model_be(f3, a);
      r.wdata = model_wdata(f3, wd);
      exp_req.push_back(r);
    end
    @(posedge clk);
    #1;
    ex_valid   = 1'b0;
    ex_addr    = $urandom;
    ex_wdata   = $urandom;
    ex_funct3  = 3'($urandom_range(0, 7));
    if (err) begin
      check("err_pulse", lsu_err, 1);
      check("err_no_req", dmem_req, 0);
      check("err_ready", ex_ready, 1);
      return;
    end
    check("req_after_accept", dmem_req, 1);
    repeat (gd) begin
      dmem_rvalid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    dmem_rvalid = 1'b0;
    dmem_gnt    = 1'b1;
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    check("req_drop_after_gnt", dmem_req, 0);
    repeat (rvd) begin
      dmem_gnt = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    dmem_gnt = 1'b0;
    if (abort) begin
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check_reset_outputs();
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b0;
      check("abort_no_wb", lsu_rd_wen, 0);
      check("abort_ready", ex_ready, 1);
      return;
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    if (!st && rd != 0) begin
      w.rd   = rd;
      w.data = model_load(f3, a, rdata);
      exp_wb.push_back(w);
    end
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    dmem_rdata  = $urandom;
    check("wb_timing", lsu_rd_wen, (!st && rd != 0));
    check("ready_at_wb", ex_ready, 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    bit          st;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
    run_op(0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80FF_0000, 0, 0, 0);
    run_op(0, 3'b100, 32'h103, 32'h0, 5'd8, 32'h80FF_0000, 0, 1, 0);
    run_op(1, 3'b001, 32'h202, 32'h0000_1234, 5'd3, 32'h0, 1, 0, 0);
    run_op(0, 3'b010, 32'h101, 32'h0, 5'd9, 32'h0, 0, 0, 0);
    run_op(0, 3'b101, 32'h302, 32'h0, 5'd10, 32'h8001_7FFF, 4, 2, 0);
    run_op(0, 3'b010, 32'h400, 32'h0, 5'd11, 32'h1234_5678, 1, 2, 1);
    run_op(0, 3'b001, 32'h502, 32'h0, 5'd12, 32'hC3A5_0000, 0, 0, 0);
    run_op(0, 3'b010, 32'h600, 32'h0, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      if (st) begin
        f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 2));
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        a = a & ~(32'(op_bytes(f3)) - 32'd1);
      end
      run_op(st, f3, a, $urandom, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 24) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("req_queue_drained", exp_req.size(), 0);
    check("wb_queue_drained", exp_wb.size(), 0);
    check("err_pending_drained", err_pend, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gs_lsu.md
# gs_lsu

Load/store unit stage for the GoldenSnitch core. It accepts one memory operation at a time from the execute stage and drives a single-outstanding data-memory request/grant/response bus. For loads, it aligns and sign- or zero-extends the returned word and writes it through the register file's `lsu_rd_*` write port. Misaligned or illegal operations are flagged and never reach memory.

## Interface
- `ADDR_W`, default 32: data-memory address width.
- `clk`  in  1: core clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `ex_valid`  in  1: execute stage presents a memory operation.
- `ex_ready`  out  1: LSU can accept an operation; equals (state == IDLE).
- `ex_is_store`  in  1: 1 = store, 0 = load.
- `ex_funct3`  in  3: RV32I width/sign code (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- `ex_addr`  in  ADDR_W: effective byte address.
- `ex_wdata`  in  32: store data, right-aligned.
- `ex_rd_addr`  in  5: load destination register.
- `dmem_req`  out  1: request valid.
- `dmem_gnt`  in  1: request accepted this cycle.
- `dmem_addr`  out  ADDR_W: word-aligned address ({addr[ADDR_W-1:2], 2'b00}).
- `dmem_we`  out  1: write enable.
- `dmem_be`  out  4: byte enables.
- `dmem_wdata`  out  32: lane-replicated store data.
- `dmem_rvalid`  in  1: response valid (loads and stores).
- `dmem_rdata`  in  32: load response word.
- `lsu_rd_wen`  out  1: register-file write strobe (one-cycle pulse).
- `lsu_rd_addr`  out  5: register-file write index.
- `lsu_rd_data`  out  32: extended load result.
- `lsu_err`  out  1: one-cycle pulse for a misaligned or illegal operation.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: on `ex_valid && ex_ready`, latch the operation.
  - If misaligned or illegal, stay in IDLE and pulse `lsu_err` the next cycle.
  - Otherwise go to REQ.
- Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
- Illegal: load funct3 ∈ {011, 110, 111}, or store funct3[2]=1.
- REQ: `dmem_req`=1 and all `dmem_*` request outputs held stable until `dmem_gnt`; then go to RESP. `dmem_req` drops the cycle after the grant.
- RESP: wait for `dmem_rvalid`, then return to IDLE.
  - Load: register `lsu_rd_wen`=(rd≠0), `lsu_rd_addr`, and `lsu_rd_data`, valid the cycle after `rvalid`.
  - Store: no writeback.
- Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Store data: byte replicated ×4; half replicated ×2; word passed through.
- Load data: select the lane by addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- `dmem_rvalid` outside RESP is ignored.
- `dmem_gnt` outside REQ is ignored.

## Timing
- Reset values:
  - State IDLE, so `ex_ready`=1 after the reset edge.
  - `dmem_req`=0, `dmem_we`=0, `dmem_be`=0, `dmem_addr`=0, `dmem_wdata`=0.
  - `lsu_rd_wen`=0, `lsu_rd_addr`=0, `lsu_rd_data`=0, `lsu_err`=0.
- Accept at cycle T → `dmem_req` high from T+1.
- Grant at G → RESP from G+1.
- `rvalid` at R (R ≥ G+1) → `lsu_rd_wen` at R+1, with `ex_ready`=1 in cycle R+1.
- Best-case load latency, accept to writeback: 3 cycles (gnt at T+1, rvalid at T+2, writeback at T+3).
- Error path: `lsu_err` at T+1, `ex_ready` stays 1, and a new operation may be accepted at T+1.
- Back-to-back: a new operation may be accepted in the same cycle as the previous writeback pulse.
- Reset mid-operation: abort immediately, drop `dmem_req`, no writeback, and ignore any late `rvalid`.
- `lsu_rd_wen` and `lsu_err` are never high for more than one cycle per operation.

## Structure
- `gs_pkg` additions:
  - `lsu_state_e` (IDLE/REQ/RESP).
  - Funct3 constants `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`.
  - `lsu_op_t` struct: is_store, funct3, addr, wdata, rd.
- Sub-module `gs_lsu_align` (combinational):
  - Store side: produces byte enables, replicated wdata, and the misaligned/illegal flag.
  - Load side: extracts and extends the load lane.
- `gs_lsu` owns the FSM and all registers.

## Test plan
- LW x5 at 0x100, gnt same cycle as req, `dmem_rdata`=0xDEADBEEF, rvalid next cycle → `lsu_rd_wen`=1, `lsu_rd_addr`=5, `lsu_rd_data`=0xDEADBEEF, 3 cycles after accept.
- LB at 0x103, rdata 0x80FF_0000 → `lsu_rd_data`=0xFFFF_FF80; LBU at the same address → 0x0000_0080.
- SH 0x1234 at 0x202 → `dmem_addr`=0x200, `dmem_be`=1100, `dmem_wdata`=0x12341234, `dmem_we`=1, no `lsu_rd_wen`.
- LW at 0x101 → `lsu_err` pulses once, `dmem_req` never asserts, `ex_ready` stays 1.
- Grant withheld 4 cycles → `dmem_req`, `dmem_addr`, and `dmem_be` stable throughout; `ex_ready`=0 until the writeback cycle.
- Reset asserted while in RESP, then rvalid arrives → no writeback; all outputs at reset values; next load completes normally.
